// File: rtl/apb_uart_csr_fifo.sv
// APB4 register file for the UART with TX/RX byte FIFOs, programmable wait states,
// slave-error checking and a level interrupt.

module uart_csr_sfifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [DEPTH];
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
            else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

module apb_uart_csr_fifo #(
    parameter int ADDR_WIDTH  = 12,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    input  logic [3:0]            pstrb,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            lcr_o,
    output logic [15:0]           ocr_o,
    output logic [7:0]            mcr_o,
    input  logic [7:0]            msr_i,
    output logic                  irq
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  lcr_q, lcr_d, mcr_q, mcr_d, msr_q;
    logic [15:0] ocr_q, ocr_d;
    logic [2:0]  ier_q, ier_d;
    logic        oe_q, oe_d;

    logic [3:0]  idx;
    logic        access, done, err, wr, rd;
    logic        tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic        rx_pop, rx_flush, rx_full, rx_empty;
    logic [7:0]  rx_head, lsr, iir;
    logic [2:0]  pend;
    logic [1:0]  iid;
    logic [31:0] rdata_mux;
    logic        unused_bits;

    assign unused_bits = ^{paddr[ADDR_WIDTH-1:6], paddr[1:0], pwdata[31:16]};

    // SETUP is the first penable cycle after the setup phase; ACCESS covers the rest.
    assign idx    = paddr[5:2];
    assign access = (state_q != S_IDLE) && psel && penable;
    assign done   = access && (wait_q == WS);
    assign wr     = done && pwrite && !err;
    assign rd     = done && !pwrite && !err;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (psel && !penable) state_d = S_SETUP;
            end
            default: begin
                if (!psel || done) begin
                    state_d = S_IDLE;
                    wait_d  = '0;
                end else if (penable) begin
                    state_d = S_ACCESS;
                    wait_d  = wait_q + 4'd1;
                end
            end
        endcase
    end

    assign tx_pop = tx_valid && tx_ready;

    always_comb begin
        err = 1'b0;
        case (idx)
            4'd0:                   err = !pwrite || (pstrb[0] && tx_full && !tx_pop);
            4'd1, 4'd4, 4'd6, 4'd9: err = pwrite;
            4'd5:                   err = !pwrite;
            4'd2, 4'd3, 4'd7, 4'd8: err = 1'b0;
            default:                err = 1'b1;
        endcase
    end

    assign tx_push  = wr && (idx == 4'd0) && pstrb[0];
    assign tx_flush = wr && (idx == 4'd5) && pstrb[0] && pwdata[2];
    assign rx_flush = wr && (idx == 4'd5) && pstrb[0] && pwdata[1];
    assign rx_pop   = rd && (idx == 4'd1) && !rx_empty;

    uart_csr_sfifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (pclk),
        .rst_n (preset_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .wdata (pwdata[7:0]),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_csr_sfifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (pclk),
        .rst_n (preset_n),
        .push  (rx_valid),
        .pop   (rx_pop),
        .flush (rx_flush),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_valid = !tx_empty;

    always_comb begin
        lcr_d = lcr_q;
        ocr_d = ocr_q;
        mcr_d = mcr_q;
        ier_d = ier_q;
        oe_d  = oe_q;
        if (wr && idx == 4'd2 && pstrb[0]) lcr_d = pwdata[7:0];
        if (wr && idx == 4'd3 && pstrb[0]) ocr_d[7:0] = pwdata[7:0];
        if (wr && idx == 4'd3 && pstrb[1]) ocr_d[15:8] = pwdata[15:8];
        if (wr && idx == 4'd7 && pstrb[0]) mcr_d = pwdata[7:0];
        if (wr && idx == 4'd8 && pstrb[0]) ier_d = pwdata[2:0];
        if (rd && idx == 4'd4) oe_d = 1'b0;
        // A new overrun in the same cycle as the LSR read stays visible.
        if (rx_valid && rx_full && !rx_pop && !rx_flush) oe_d = 1'b1;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            lcr_q   <= '0;
            ocr_q   <= '0;
            mcr_q   <= '0;
            ier_q   <= '0;
            oe_q    <= 1'b0;
            msr_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            lcr_q   <= lcr_d;
            ocr_q   <= ocr_d;
            mcr_q   <= mcr_d;
            ier_q   <= ier_d;
            oe_q    <= oe_d;
            msr_q   <= msr_i;
        end
    end

    assign lsr  = {1'b0, tx_empty && !tx_valid, tx_empty, 3'b000, oe_q, !rx_empty};
    assign pend = ier_q & {oe_q, tx_empty, !rx_empty};
    assign irq  = |pend;
    assign iid  = pend[2] ? 2'd3 : pend[0] ? 2'd2 : pend[1] ? 2'd1 : 2'd0;
    assign iir  = {5'b0, iid, !irq};

    always_comb begin
        rdata_mux = '0;
        case (idx)
            4'd1:    rdata_mux = rx_empty ? 32'h0 : {24'h0, rx_head};
            4'd2:    rdata_mux = {24'h0, lcr_q};
            4'd3:    rdata_mux = {16'h0, ocr_q};
            4'd4:    rdata_mux = {24'h0, lsr};
            4'd6:    rdata_mux = {24'h0, msr_q};
            4'd7:    rdata_mux = {24'h0, mcr_q};
            4'd8:    rdata_mux = {29'h0, ier_q};
            4'd9:    rdata_mux = {24'h0, iir};
            default: rdata_mux = '0;
        endcase
    end

    assign pready  = done;
    assign pslverr = done && err;
    assign prdata  = rd ? rdata_mux : 32'h0;
    assign lcr_o   = lcr_q;
    assign ocr_o   = ocr_q;
    assign mcr_o   = mcr_q;
endmodule

// File: tb/tb_apb_uart_csr_fifo.sv
// Directed bench for apb_uart_csr_fifo: main instance with 3 wait states, a second
// instance with 2 wait states used for the reset-during-access scenario.

module tb_apb_uart_csr_fifo;
    logic        pclk = 1'b0;
    logic        preset_n, rst2_n;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        tx_ready, rx_valid;
    logic [7:0]  rx_data, msr_i;

    logic [31:0] prdata, prdata_2;
    logic        pready, pready_2, pslverr, pslverr_2;
    logic [7:0]  tx_data, tx_data_2, lcr_o, lcr_o_2, mcr_o, mcr_o_2;
    logic        tx_valid, tx_valid_2, irq, irq_2;
    logic [15:0] ocr_o, ocr_o_2;

    int n_checks = 0;
    int n_errors = 0;
    int last_waits;

    always #5 pclk = ~pclk;

    apb_uart_csr_fifo #(.ADDR_WIDTH(12), .TX_DEPTH(16), .RX_DEPTH(16), .WAIT_STATES(3)) u_dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .lcr_o(lcr_o), .ocr_o(ocr_o), .mcr_o(mcr_o),
        .msr_i(msr_i), .irq(irq)
    );

    apb_uart_csr_fifo #(.ADDR_WIDTH(12), .TX_DEPTH(16), .RX_DEPTH(16), .WAIT_STATES(2)) u_ws2 (
        .pclk(pclk), .preset_n(rst2_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_2), .pready(pready_2),
        .pslverr(pslverr_2), .tx_data(tx_data_2), .tx_valid(tx_valid_2), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .lcr_o(lcr_o_2), .ocr_o(ocr_o_2), .mcr_o(mcr_o_2),
        .msr_i(msr_i), .irq(irq_2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb(input logic wr_n_rd, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rdat, output logic err);
        bit got;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr_n_rd; paddr = addr; pwdata = wd; pstrb = st;
        @(posedge pclk); #1;
        penable = 1'b1;
        got = 1'b0; rdat = '0; err = 1'b0; last_waits = 0;
        for (int n = 0; n < 32 && !got; n++) begin
            @(negedge pclk);
            if (pready) begin
                got = 1'b1; rdat = prdata; err = pslverr;
            end else begin
                last_waits++;
                @(posedge pclk); #1;
            end
        end
        if (!got) check("apb_timeout", 32'd0, 32'd1);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_wr(input logic [11:0] addr, input logic [31:0] wd, input logic [3:0] st,
                          output logic err);
        logic [31:0] dummy;
        apb(1'b1, addr, wd, st, dummy, err);
    endtask

    task automatic apb_rd(input logic [11:0] addr, output logic [31:0] rdat, output logic err);
        apb(1'b0, addr, 32'h0, 4'h0, rdat, err);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          wr_errs;

        preset_n = 1'b0; rst2_n = 1'b0;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
        tx_ready = 0; rx_valid = 0; rx_data = '0; msr_i = 8'h00;
        repeat (3) @(negedge pclk);
        check("rst_pready", {31'h0, pready}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pslverr", {31'h0, pslverr}, 32'h0);
        check("rst_irq_txv", {30'h0, irq, tx_valid}, 32'h0);
        check("rst_regs", {lcr_o, ocr_o, mcr_o}, 32'h0);
        preset_n = 1'b1; rst2_n = 1'b1;

        // Wait states and byte strobes
        apb_wr(12'h008, 32'h0000_00A5, 4'b0001, e);
        check("lcr_wr_waits", last_waits, 3);
        check("lcr_wr_err", {31'h0, e}, 32'h0);
        apb_rd(12'h008, rd, e);
        check("lcr_rd", rd, 32'h0000_00A5);
        check("lcr_rd_waits", last_waits, 3);
        apb_wr(12'h008, 32'hFFFF_FF5A, 4'b0010, e);
        check("lcr_strb_off", {24'h0, lcr_o}, 32'hA5);
        apb_wr(12'h00C, 32'h1234_5678, 4'b0011, e);
        apb_wr(12'h00C, 32'h0000_AB00, 4'b0010, e);
        check("ocr_bytes", {16'h0, ocr_o}, 32'h0000_AB78);
        apb_wr(12'h01C, 32'hFFFF_FFFF, 4'b1111, e);
        check("mcr_all", {24'h0, mcr_o}, 32'hFF);
        apb_wr(12'h020, 32'hFFFF_FFFF, 4'b1111, e);
        apb_rd(12'h020, rd, e);
        check("ier_unused0", rd, 32'h7);
        apb_wr(12'h020, 32'h0, 4'b0001, e);

        // Reset the 2-wait-state instance in the middle of an access; main sees psel drop
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = 12'h008; pwdata = 32'h3C; pstrb = 4'b0001;
        @(posedge pclk); #1;
        penable = 1;
        @(negedge pclk);
        check("ws2_acc0_pready", {31'h0, pready_2}, 32'h0);
        @(posedge pclk); #1;
        @(negedge pclk);
        check("ws2_acc1_pready", {31'h0, pready_2}, 32'h0);
        rst2_n = 1'b0; psel = 0; penable = 0; pwrite = 0;
        #1;
        check("ws2_rst_pready", {31'h0, pready_2}, 32'h0);
        check("ws2_rst_prdata", prdata_2, 32'h0);
        @(negedge pclk);
        check("ws2_rst_lcr", {24'h0, lcr_o_2}, 32'h0);
        check("abort_no_commit", {24'h0, lcr_o}, 32'hA5);
        rst2_n = 1'b1;

        // Fill TX FIFO with the core stalled
        wr_errs = 0;
        for (int i = 0; i < 16; i++) begin
            apb_wr(12'h000, 32'(i), 4'b0001, e);
            if (e) wr_errs++;
        end
        check("tx_fill_errs", wr_errs, 0);
        apb_wr(12'h000, 32'hEE, 4'b0001, e);
        check("tx_full_err", {31'h0, e}, 32'h1);
        apb_wr(12'h000, 32'hDD, 4'b0000, e);
        check("tdr_nostrb_err", {31'h0, e}, 32'h0);
        apb_rd(12'h010, rd, e);
        check("lsr_tx_full", rd, 32'h00);
        apb_wr(12'h020, 32'h2, 4'b0001, e);
        check("irq_thre_off", {31'h0, irq}, 32'h0);

        @(posedge pclk); #1;
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge pclk);
            check($sformatf("tx_drain%0d", i), {23'h0, tx_valid, tx_data}, 32'h100 | 32'(i));
        end
        @(negedge pclk);
        check("tx_empty_after", {31'h0, tx_valid}, 32'h0);
        check("irq_thre_on", {31'h0, irq}, 32'h1);
        tx_ready = 1'b0;
        apb_rd(12'h010, rd, e);
        check("lsr_tx_empty", rd, 32'h60);
        apb_rd(12'h024, rd, e);
        check("iir_thre", rd, 32'h02);

        // RX overrun
        apb_wr(12'h020, 32'h5, 4'b0001, e);
        check("irq_ier5_idle", {31'h0, irq}, 32'h0);
        for (int i = 0; i < 17; i++) begin
            @(posedge pclk); #1;
            rx_valid = 1'b1; rx_data = 8'h40 + 8'(i);
        end
        @(posedge pclk); #1;
        rx_valid = 1'b0;
        @(negedge pclk);
        check("irq_oe", {31'h0, irq}, 32'h1);
        apb_rd(12'h024, rd, e);
        check("iir_oe", rd, 32'h06);
        apb_rd(12'h010, rd, e);
        check("lsr_oe_low", rd & 32'h3F, 32'h23);
        check("lsr_temt", rd & 32'h40, 32'h40);
        apb_rd(12'h010, rd, e);
        check("lsr_oe_clr", rd & 32'h3F, 32'h21);
        apb_rd(12'h024, rd, e);
        check("iir_dr", rd, 32'h04);

        // Error responses
        apb_wr(12'h004, 32'h99, 4'b0001, e);
        check("wr_rdr_err", {31'h0, e}, 32'h1);
        apb_rd(12'h028, rd, e);
        check("rd_unmapped_err", {31'h0, e}, 32'h1);
        check("rd_unmapped_data", rd, 32'h0);
        apb_wr(12'h010, 32'h0, 4'b0001, e);
        check("wr_lsr_err", {31'h0, e}, 32'h1);
        apb_rd(12'h000, rd, e);
        check("rd_tdr_err", {31'h0, e}, 32'h1);
        apb_rd(12'h014, rd, e);
        check("rd_fcr_err", {31'h0, e}, 32'h1);

        for (int i = 0; i < 16; i++) begin
            apb_rd(12'h004, rd, e);
            check($sformatf("rdr%0d", i), {23'h0, e, rd[7:0]}, 32'h40 + 32'(i));
        end
        apb_rd(12'h004, rd, e);
        check("rdr_empty", {rd[30:0], e}, 32'h0);
        apb_rd(12'h010, rd, e);
        check("lsr_rx_drained", rd, 32'h60);
        check("irq_quiet", {31'h0, irq}, 32'h0);

        // Modem status sampling
        msr_i = 8'h5A;
        apb_rd(12'h018, rd, e);
        check("msr", rd, 32'h5A);

        // FIFO flush
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            rx_valid = 1'b1; rx_data = 8'h70 + 8'(i);
        end
        @(posedge pclk); #1;
        rx_valid = 1'b0;
        apb_wr(12'h000, 32'h11, 4'b0001, e);
        apb_wr(12'h000, 32'h22, 4'b0001, e);
        apb_rd(12'h010, rd, e);
        check("lsr_pre_flush", rd, 32'h01);
        apb_wr(12'h014, 32'h6, 4'b0001, e);
        check("fcr_wr_err", {31'h0, e}, 32'h0);
        apb_rd(12'h010, rd, e);
        check("lsr_post_flush", rd, 32'h60);
        check("tx_valid_flush", {31'h0, tx_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
